// File: rtl/dec_count1.sv
// Single-decade synchronous BCD counter (0..9) with asynchronous active-low clear.
// Illegal codes 10..15 recover to 0 on the next edge.
module dec_count1 (
   input  logic clk,
   input  logic rst,
   output logic QA,
   output logic QB,
   output logic QC,
   output logic QD
);

   logic [3:0] cnt_q;
   logic [3:0] cnt_d;

   // 9 wraps to 0; 10..15 are illegal and also collapse to 0.
   always_comb begin
      cnt_d = 4'd0;
      if (cnt_q < 4'd9) begin
         cnt_d = cnt_q + 4'd1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= 4'd0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign QA = cnt_q[0];
   assign QB = cnt_q[1];
   assign QC = cnt_q[2];
   assign QD = cnt_q[3];

endmodule

// File: tb/tb_dec_count1.sv
// Directed self-checking bench for dec_count1: reset hold, counting, wrap,
// asynchronous mid-count clear, restart and illegal-state recovery.
module tb_dec_count1;

   logic clk;
   logic rst;
   logic QA;
   logic QB;
   logic QC;
   logic QD;
   logic [3:0] q;

   int total;
   int bad;

   dec_count1 dut (
      .clk (clk),
      .rst (rst),
      .QA  (QA),
      .QB  (QB),
      .QC  (QC),
      .QD  (QD)
   );

   assign q = {QD, QC, QB, QA};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %b want %b at %0t", tag, got, exp, $time);
      end
   endtask

   // One rising edge, then sample on the following falling edge.
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      logic [3:0] illegal [3];
      total = 0;
      bad   = 0;
      illegal[0] = 4'b1100;
      illegal[1] = 4'b1010;
      illegal[2] = 4'b1111;

      // Hold reset for 50 ns with the clock running.
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         #10;
         check("reset_hold", q, 4'b0000);
      end

      // Release midway between edges, then count 1..9.
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("after_release", q, 4'b0000);
      for (int i = 1; i <= 9; i++) begin
         step();
         check("count_up", q, 4'(i));
      end

      step();
      check("wrap_9_to_0", q, 4'b0000);

      // 25 edges from reset in total.
      for (int i = 0; i < 15; i++) step();
      check("edge_25", q, 4'b0101);

      step();
      step();
      check("count_to_7", q, 4'b0111);

      // Asynchronous clear midway between edges.
      #2;
      rst = 1'b0;
      #1;
      check("async_clear", q, 4'b0000);
      for (int i = 0; i < 3; i++) begin
         step();
         check("edges_in_reset", q, 4'b0000);
      end

      // Restart after mid-count reset.
      rst = 1'b1;
      for (int i = 0; i < 3; i++) step();
      check("restart_3", q, 4'b0011);

      // Clear from the highest legal state.
      for (int i = 0; i < 6; i++) step();
      check("reach_9", q, 4'b1001);
      #2;
      rst = 1'b0;
      #1;
      check("async_clear_at_9", q, 4'b0000);
      @(negedge clk);
      rst = 1'b1;

      // Illegal states recover to 0 in one edge.
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         force dut.cnt_q = illegal[k];
         #1;
         check("forced_state", q, illegal[k]);
         release dut.cnt_q;
         step();
         check("illegal_recover", q, 4'b0000);
         step();
         check("after_recover", q, 4'b0001);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
